// File: rtl/instr_fetch_unit_pkg.sv
// Package shared by the fetch front end and the decoder.
//  - RV32 base opcode values as the decoder sees them in instr[6:0]
//  - INSTR_NOP: canonical ADDI x0,x0,0, presented when no instruction is valid
//  - fetch_state_e: fetch sequencer states
package instr_fetch_unit_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit.
//  imem_req_*  : word read requests toward instruction memory (valid/ready)
//  imem_rsp_*  : in-order read data, no backpressure
//  redirect_*  : restart request from branch/jump resolution
//  instr*, opcode/func3/func7 : head instruction toward decode (valid/ready)
// modport master: the fetch unit side; modport slave: memory/decode/branch side.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc, opcode, func3, func7,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc, opcode, func3, func7,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// Synchronous FIFO with flush, used as the prefetch buffer.
//  clk, rst   : clock, synchronous active-high reset (pointers/count only)
//  flush      : empties the FIFO; dominates push and pop
//  push/push_data, pop : write and read strobes (caller keeps them legal)
//  head_data  : oldest entry, meaningful only when count != 0
//  count      : occupancy, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_ONE;
      if (pop)  rd_d = rd_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (!push && pop) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_q] <= push_data;
  end

  assign head_data = mem[rd_q];
  assign count     = count_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end.
//  clk, rst : clock, synchronous active-high reset
//  bus      : instr_fetch_unit_if.master (imem request/response, redirect, decode handshake)
// Issues word reads under a credit rule that reserves FIFO space for every
// in-flight response, tags responses with their PC through a small in-order PC
// queue, and discards responses from the old path after a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int PQ_DEPTH = (MAX_OUTST < 2) ? 2 : MAX_OUTST;
  localparam int PQ_AW    = $clog2(PQ_DEPTH);

  localparam logic [CW-1:0]    CNT_ONE   = 1;
  localparam logic [CW-1:0]    OUST_LIM  = MAX_OUTST[CW-1:0];
  localparam logic [CW:0]      DEPTH_LIM = FIFO_DEPTH[CW:0];
  localparam logic [PQ_AW-1:0] PQ_ONE    = 1;
  localparam logic [PQ_AW-1:0] PQ_LAST   = PQ_AW'(PQ_DEPTH - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    outst_q, outst_d, stale_q, stale_d;
  logic [PQ_AW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [31:0]      pcq_mem [PQ_DEPTH];

  logic          req_valid, accept, rsp, push, pop, head_valid;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;
  logic [31:0]   instr_w;

  function automatic logic [PQ_AW-1:0] pq_next(input logic [PQ_AW-1:0] ptr);
    if (ptr == PQ_LAST) return '0;
    return ptr + PQ_ONE;
  endfunction

  // Credit rule: FIFO entries plus in-flight requests never exceed the depth,
  // so a response always has a slot. Depends only on flops, so it holds
  // steady until accepted or a redirect changes state.
  always_comb begin
    req_valid = (state_q == ST_FETCH) && (outst_q < OUST_LIM) &&
                (({1'b0, fifo_count} + {1'b0, outst_q}) < DEPTH_LIM);
  end

  assign accept     = req_valid & bus.imem_req_ready;
  assign rsp        = bus.imem_rsp_valid;
  assign head_valid = (fifo_count != '0);
  assign pop        = head_valid & bus.instr_ready;
  // Old-path responses and responses coinciding with a redirect never enter the FIFO.
  assign push       = rsp && (stale_q == '0) && !bus.redirect_valid;

  always_comb begin
    outst_d = outst_q;
    if (accept && !rsp)      outst_d = outst_q + CNT_ONE;
    else if (!accept && rsp) outst_d = outst_q - CNT_ONE;

    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) fetch_pc_d = bus.redirect_pc & ~32'd3;
    else if (accept)        fetch_pc_d = fetch_pc_q + 32'd4;

    // Everything still in flight after this edge, including a request
    // accepted on the redirect edge, belongs to the abandoned path.
    stale_d = stale_q;
    if (bus.redirect_valid)           stale_d = outst_d;
    else if (rsp && stale_q != '0)    stale_d = stale_q - CNT_ONE;

    pcq_wr_d = accept ? pq_next(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d = rsp    ? pq_next(pcq_rd_q) : pcq_rd_q;

    state_d = state_q;
    case (state_q)
      ST_BOOT:            state_d = ST_FETCH;
      ST_FETCH, ST_DRAIN: state_d = (stale_d != '0) ? ST_DRAIN : ST_FETCH;
      default:            state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      stale_q    <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      pcq_wr_q   <= pcq_wr_d;
      pcq_rd_q   <= pcq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) pcq_mem[pcq_wr_q] <= fetch_pc_q;
  end

  sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (push),
    .push_data ({pcq_mem[pcq_rd_q], bus.imem_rsp_data}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  always_comb begin
    instr_w = head_valid ? fifo_head[31:0] : INSTR_NOP;
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = instr_w;
  // With nothing buffered, report the address about to be fetched.
  assign bus.instr_pc       = head_valid ? fifo_head[63:32] : fetch_pc_q;
  assign bus.opcode         = instr_w[6:0];
  assign bus.func3          = instr_w[14:12];
  assign bus.func7          = instr_w[31:25];
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;
  localparam int          MAX_OUTST  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int cyc      = 0;

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_instr_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[26:2], 7'b0010011};
  endfunction

  // One clock: sample handshakes at negedge, then after the edge update the
  // memory model and drive at most one in-order response.
  task automatic step();
    logic        acc, pp;
    logic [31:0] aa, pi, ppc;
    @(negedge clk);
    acc = bus.imem_req_valid && bus.imem_req_ready;
    aa  = bus.imem_req_addr;
    pp  = bus.instr_valid && bus.instr_ready;
    pi  = bus.instr;
    ppc = bus.instr_pc;
    if (!rst) begin
      n_checks++;
      if (int'(dut.u_fifo.count_q) > FIFO_DEPTH || int'(dut.outst_q) > MAX_OUTST) begin
        n_fail++;
        $display("FAIL overflow: fifo count %0d outstanding %0d, limits %0d/%0d",
                 dut.u_fifo.count_q, dut.outst_q, FIFO_DEPTH, MAX_OUTST);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) mq.delete();
    else begin
      if (acc) begin
        mq.push_back('{cyc + lat - 1, aa});
        acc_log.push_back(aa);
      end
      if (pp) begin
        pop_pc_log.push_back(ppc);
        pop_instr_log.push_back(pi);
      end
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); end
    n_checks++; if (bus.imem_req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", bus.imem_req_addr, RESET_PC); end
    n_checks++; if (bus.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", bus.instr); end
    n_checks++; if (bus.instr_pc !== RESET_PC) begin n_fail++; $display("FAIL reset_instr_pc: got %h want %h", bus.instr_pc, RESET_PC); end
  endtask

  task automatic test_fetch_stream();
    lat = 1;
    pop_pc_log.delete(); pop_instr_log.delete(); acc_log.delete();
    rst = 1'b0;
    step();
    n_checks++; if (bus.imem_req_valid !== 1'b1 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1: req_valid %b instr_valid %b want 1/0", bus.imem_req_valid, bus.instr_valid); end
    step();
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c2: instr_valid %b want 0", bus.instr_valid); end
    step();
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL stream_c3_valid: got %b want 1", bus.instr_valid); end
    n_checks++; if (bus.instr_pc !== 32'h0 || bus.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL stream_c3_word: pc %h instr %h want 00000000/00000013", bus.instr_pc, bus.instr); end
    n_checks++; if (bus.opcode !== 7'h13 || bus.func3 !== 3'd0 || bus.func7 !== 7'd0) begin n_fail++; $display("FAIL stream_fields: %h %h %h want 13 0 0", bus.opcode, bus.func3, bus.func7); end
    step();
    // word at 0x4 is 0x93: func7 0, func3 0, opcode 13
    n_checks++; if (bus.instr_pc !== 32'h4 || bus.instr !== 32'h0000_0093) begin n_fail++; $display("FAIL stream_c4_word: pc %h instr %h want 00000004/00000093", bus.instr_pc, bus.instr); end
    for (int i = 0; i < 12; i++) step();
    n_checks++; if (pop_pc_log.size() < 10) begin n_fail++; $display("FAIL stream_throughput: %0d pops want >=10", pop_pc_log.size()); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (acc_log[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_addr[%0d]: got %h want %h", k, acc_log[k], 32'(4 * k)); end
    end
    for (int k = 0; k < pop_pc_log.size(); k++) begin
      n_checks++;
      if (pop_pc_log[k] !== 32'(4 * k) || pop_instr_log[k] !== mem_word(32'(4 * k))) begin
        n_fail++; $display("FAIL stream_pop[%0d]: pc %h instr %h want %h/%h", k, pop_pc_log[k], pop_instr_log[k], 32'(4 * k), mem_word(32'(4 * k)));
      end
    end
  endtask

  task automatic test_backpressure();
    int          base;
    logic [31:0] exp;
    exp = pop_pc_log[$] + 32'd4;
    bus.instr_ready = 1'b0;
    base = pop_pc_log.size();
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (dut.u_fifo.count_q !== 3'(FIFO_DEPTH)) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", dut.u_fifo.count_q, FIFO_DEPTH); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", bus.imem_req_valid); end
    n_checks++; if (dut.outst_q !== 3'd0) begin n_fail++; $display("FAIL bp_outst: got %0d want 0", dut.outst_q); end
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp) begin n_fail++; $display("FAIL bp_head: valid %b pc %h want 1/%h", bus.instr_valid, bus.instr_pc, exp); end
    n_checks++; if (pop_pc_log.size() != base) begin n_fail++; $display("FAIL bp_no_pop: pops %0d want %0d", pop_pc_log.size(), base); end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    n_checks++; if (pop_pc_log.size() < base + FIFO_DEPTH + 2) begin n_fail++; $display("FAIL bp_drain_count: pops %0d want >=%0d", pop_pc_log.size(), base + FIFO_DEPTH + 2); end
    for (int k = base; k < pop_pc_log.size(); k++) begin
      n_checks++;
      if (pop_pc_log[k] !== exp || pop_instr_log[k] !== mem_word(exp)) begin
        n_fail++; $display("FAIL bp_order[%0d]: pc %h instr %h want %h/%h", k, pop_pc_log[k], pop_instr_log[k], exp, mem_word(exp));
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_redirect_stale();
    bit          found;
    int          pbase, abase;
    logic [31:0] exp;
    lat = 3;
    for (int i = 0; i < 12; i++) step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() == 2 && !bus.imem_rsp_valid) found = 1'b1;
      else step();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL stale_setup: in-flight %0d want 2", mq.size()); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    step();
    bus.redirect_valid = 1'b0;
    pbase = pop_pc_log.size();
    abase = acc_log.size();
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stale_flush: instr_valid %b want 0", bus.instr_valid); end
    n_checks++; if (dut.stale_q !== 3'd2) begin n_fail++; $display("FAIL stale_count: got %0d want 2", dut.stale_q); end
    n_checks++; if (bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stale_drain_req: got %b want 0", bus.imem_req_valid); end
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (acc_log.size() <= abase || acc_log[abase] !== 32'h100) begin n_fail++; $display("FAIL stale_first_addr: got %h want 00000100", (acc_log.size() > abase) ? acc_log[abase] : 32'hx); end
    n_checks++; if (pop_pc_log.size() < pbase + 4) begin n_fail++; $display("FAIL stale_pops: %0d want >=%0d", pop_pc_log.size(), pbase + 4); end
    exp = 32'h100;
    for (int k = pbase; k < pop_pc_log.size(); k++) begin
      n_checks++;
      if (pop_pc_log[k] !== exp || pop_instr_log[k] !== mem_word(exp)) begin
        n_fail++; $display("FAIL stale_path[%0d]: pc %h instr %h want %h/%h", k, pop_pc_log[k], pop_instr_log[k], exp, mem_word(exp));
      end
      exp = exp + 32'd4;
    end
    lat = 1;
  endtask

  task automatic test_redirect_collide();
    bit          found;
    int          base;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_rsp_valid && bus.instr_valid) found = 1'b1;
      else step();
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL collide_setup: rsp %b instr_valid %b want 1/1", bus.imem_rsp_valid, bus.instr_valid); end
    exp  = pop_pc_log[$] + 32'd4;
    base = pop_pc_log.size();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    step();
    bus.redirect_valid = 1'b0;
    n_checks++; if (pop_pc_log.size() != base + 1) begin n_fail++; $display("FAIL collide_popcount: %0d want %0d", pop_pc_log.size(), base + 1); end
    n_checks++; if (pop_pc_log[base] !== exp) begin n_fail++; $display("FAIL collide_popped: pc %h want %h", pop_pc_log[base], exp); end
    n_checks++; if (bus.instr_valid !== 1'b0 || dut.u_fifo.count_q !== 3'd0) begin n_fail++; $display("FAIL collide_empty: valid %b count %0d want 0/0", bus.instr_valid, dut.u_fifo.count_q); end
    base = pop_pc_log.size();
    for (int i = 0; i < 15; i++) step();
    exp = 32'h200;
    n_checks++; if (pop_pc_log.size() < base + 3) begin n_fail++; $display("FAIL collide_pops: %0d want >=%0d", pop_pc_log.size(), base + 3); end
    for (int k = base; k < pop_pc_log.size(); k++) begin
      n_checks++;
      if (pop_pc_log[k] !== exp || pop_instr_log[k] !== mem_word(exp)) begin
        n_fail++; $display("FAIL collide_path[%0d]: pc %h instr %h want %h/%h", k, pop_pc_log[k], pop_instr_log[k], exp, mem_word(exp));
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_wrap();
    int          pbase, abase;
    logic [31:0] exp;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    pbase = pop_pc_log.size();
    abase = acc_log.size();
    n_checks++; if (bus.imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_align: addr %h want fffffffc", bus.imem_req_addr); end
    for (int i = 0; i < 15; i++) step();
    n_checks++; if (acc_log.size() < abase + 2) begin n_fail++; $display("FAIL wrap_accepts: %0d want >=%0d", acc_log.size(), abase + 2); end
    else begin
      n_checks++; if (acc_log[abase] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", acc_log[abase]); end
      n_checks++; if (acc_log[abase + 1] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 00000000", acc_log[abase + 1]); end
    end
    n_checks++; if (pop_pc_log.size() < pbase + 3) begin n_fail++; $display("FAIL wrap_pops: %0d want >=%0d", pop_pc_log.size(), pbase + 3); end
    exp = 32'hFFFF_FFFC;
    for (int k = pbase; k < pop_pc_log.size(); k++) begin
      n_checks++;
      if (pop_pc_log[k] !== exp || pop_instr_log[k] !== mem_word(exp)) begin
        n_fail++; $display("FAIL wrap_path[%0d]: pc %h instr %h want %h/%h", k, pop_pc_log[k], pop_instr_log[k], exp, mem_word(exp));
      end
      exp = exp + 32'd4;
    end
  endtask

  task automatic test_reset_mid();
    int abase, pbase;
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 15; i++) step();
    n_checks++; if (dut.u_fifo.count_q !== 3'(FIFO_DEPTH) || mq.size() != 0 || bus.imem_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_setup: count %0d inflight %0d want %0d/0", dut.u_fifo.count_q, mq.size(), FIFO_DEPTH); end
    rst = 1'b1;
    step();
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rmid_out: valid %b instr %h want 0/00000013", bus.instr_valid, bus.instr); end
    n_checks++; if (bus.instr_pc !== RESET_PC || bus.imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_pc: pc %h req_valid %b want %h/0", bus.instr_pc, bus.imem_req_valid, RESET_PC); end
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    abase = acc_log.size();
    pbase = pop_pc_log.size();
    for (int i = 0; i < 6; i++) step();
    n_checks++; if (acc_log.size() <= abase || acc_log[abase] !== RESET_PC) begin n_fail++; $display("FAIL rmid_refetch: got %h want %h", (acc_log.size() > abase) ? acc_log[abase] : 32'hx, RESET_PC); end
    n_checks++; if (pop_pc_log.size() <= pbase || pop_pc_log[pbase] !== RESET_PC) begin n_fail++; $display("FAIL rmid_first_pop: got %h want %h", (pop_pc_log.size() > pbase) ? pop_pc_log[pbase] : 32'hx, RESET_PC); end
  endtask

  initial begin
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b1;
    test_reset();
    test_fetch_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collide();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
